// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst sequencer.
package dma_pkg;

   // Sequencer control states.
   typedef enum logic [2:0] {
      IDLE,
      CALC,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_e;

   // AXI AxSIZE encodings (log2 of bytes per beat).
   localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
   localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
   localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
   localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
   localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
   localparam logic [2:0] AXI_SIZE_128B = 3'd7;

   // AXI bursts may not cross a 4 KB page.
   localparam int unsigned DEFAULT_BOUNDARY = 4096;

endpackage

// File: rtl/dma_burst_sequencer_if.sv
// Request and DMA-channel signals of one sequencer instance.
interface dma_burst_sequencer_if #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BEATS_WIDTH = 20
) ();

   logic                   cmd_valid_i;
   logic                   cmd_ready_o;
   logic [ADDR_WIDTH-1:0]  cmd_addr_i;
   logic [BEATS_WIDTH-1:0] cmd_beats_i;
   logic [2:0]             cmd_size_i;
   logic                   dma_start_o;
   logic [ADDR_WIDTH-1:0]  dma_addr_o;
   logic [7:0]             dma_len_o;
   logic [2:0]             dma_size_o;
   logic                   dma_busy_i;
   logic                   busy_o;
   logic                   done_o;

   // Sequencer side.
   modport master (
      input  cmd_valid_i, cmd_addr_i, cmd_beats_i, cmd_size_i, dma_busy_i,
      output cmd_ready_o, dma_start_o, dma_addr_o, dma_len_o, dma_size_o, busy_o, done_o
   );

   // Requester / DMA channel side.
   modport slave (
      output cmd_valid_i, cmd_addr_i, cmd_beats_i, cmd_size_i, dma_busy_i,
      input  cmd_ready_o, dma_start_o, dma_addr_o, dma_len_o, dma_size_o, busy_o, done_o
   );

endinterface

// File: rtl/dma_burst_calc.sv
// Beats in the next burst: min(remaining, MAX_BURST, beats left before the boundary).
module dma_burst_calc
   import dma_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BEATS_WIDTH = 20,
   parameter int unsigned MAX_BURST   = 256,
   parameter int unsigned BOUNDARY    = DEFAULT_BOUNDARY,
   parameter int unsigned BURST_WIDTH = $clog2(MAX_BURST) + 1
) (
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [BEATS_WIDTH-1:0] remaining,
   input  logic [2:0]             size,
   output logic [BURST_WIDTH-1:0] burst
);

   localparam int unsigned OFFS_WIDTH = $clog2(BOUNDARY);
   localparam int unsigned W0 = (BEATS_WIDTH > OFFS_WIDTH + 1) ? BEATS_WIDTH : OFFS_WIDTH + 1;
   localparam int unsigned CW = (W0 > BURST_WIDTH) ? W0 : BURST_WIDTH;

   logic [CW-1:0] to_bnd;
   logic [CW-1:0] rem_ext;
   logic [CW-1:0] max_ext;
   logic [CW-1:0] min_rm;

   // Three-way minimum; addr is size-aligned so to_bnd is never 0.
   always_comb begin
      to_bnd  = (CW'(BOUNDARY) - CW'(addr[OFFS_WIDTH-1:0])) >> size;
      rem_ext = CW'(remaining);
      max_ext = CW'(MAX_BURST);
      min_rm  = (rem_ext < max_ext) ? rem_ext : max_ext;
      burst   = (min_rm < to_bnd) ? min_rm[BURST_WIDTH-1:0] : to_bnd[BURST_WIDTH-1:0];
   end

endmodule

// File: rtl/dma_burst_sequencer.sv
// Splits a large transfer request into AXI-legal bursts for one DMA channel.
module dma_burst_sequencer
   import dma_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BEATS_WIDTH = 20,
   parameter int unsigned MAX_BURST   = 256,
   parameter int unsigned BOUNDARY    = DEFAULT_BOUNDARY
) (
   input logic                   m_axi_aclk,
   input logic                   m_axi_aresetn,
   dma_burst_sequencer_if.master bus
);

   localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST) + 1;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BEATS_WIDTH-1:0] rem_q, rem_d;
   logic [2:0]             size_q, size_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic [ADDR_WIDTH-1:0]  dma_addr_q, dma_addr_d;
   logic [7:0]             dma_len_q, dma_len_d;
   logic [2:0]             dma_size_q, dma_size_d;
   logic                   done_q, done_d;

   logic [BURST_WIDTH-1:0] calc_burst;
   logic [ADDR_WIDTH-1:0]  align_mask;
   logic [BEATS_WIDTH-1:0] rem_after;

   dma_burst_calc #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BEATS_WIDTH (BEATS_WIDTH),
      .MAX_BURST   (MAX_BURST),
      .BOUNDARY    (BOUNDARY),
      .BURST_WIDTH (BURST_WIDTH)
   ) u_calc (
      .addr      (addr_q),
      .remaining (rem_q),
      .size      (size_q),
      .burst     (calc_burst)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      size_d     = size_q;
      burst_d    = burst_q;
      dma_addr_d = dma_addr_q;
      dma_len_d  = dma_len_q;
      dma_size_d = dma_size_q;
      done_d     = 1'b0;
      align_mask = {ADDR_WIDTH{1'b1}} << bus.cmd_size_i;
      rem_after  = rem_q - BEATS_WIDTH'(burst_q);

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               addr_d  = bus.cmd_addr_i & align_mask;
               rem_d   = bus.cmd_beats_i;
               size_d  = bus.cmd_size_i;
               state_d = CALC;
            end
         end
         CALC: begin
            if (rem_q == '0) begin
               // Zero-beat request completes without touching the channel.
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               burst_d    = calc_burst;
               dma_addr_d = addr_q;
               dma_len_d  = 8'(calc_burst - BURST_WIDTH'(1));
               dma_size_d = size_q;
               state_d    = START;
            end
         end
         START: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.dma_busy_i) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.dma_busy_i) begin
               addr_d = addr_q + (ADDR_WIDTH'(burst_q) << size_q);
               rem_d  = rem_after;
               if (rem_after == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         dma_addr_q <= '0;
         dma_len_q  <= '0;
         dma_size_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         dma_addr_q <= dma_addr_d;
         dma_len_q  <= dma_len_d;
         dma_size_q <= dma_size_d;
         done_q     <= done_d;
      end
   end

   assign bus.cmd_ready_o = (state_q == IDLE);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.dma_start_o = (state_q == START);
   assign bus.dma_addr_o  = dma_addr_q;
   assign bus.dma_len_o   = dma_len_q;
   assign bus.dma_size_o  = dma_size_q;
   assign bus.done_o      = done_q;

endmodule
